// File: rtl/dff_pipe.sv
// dff_pipe: N-stage enabled register pipeline with a valid-bit chain,
// synchronous clear and a registered occupancy counter.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_clr    synchronous clear (wins over i_en)
//   i_en     advance enable; low holds every stage
//   i_valid  valid qualifier for i_data
//   i_data   stage-0 input data
//   o_data   last-stage data
//   o_valid  last-stage valid
//   o_taps   all stage data; bits [D*(k+1)-1 : D*k] = stage k
//   o_vtaps  per-stage valid bits; bit k = stage k
//   o_cnt    number of valid stages, 0..N
//   o_full   high when o_cnt == N
module dff_pipe #(
  parameter int unsigned D       = 16,
  parameter int unsigned N       = 4,
  parameter logic [D-1:0] RST_VAL = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_valid,
  input  logic [D-1:0]             i_data,
  output logic [D-1:0]             o_data,
  output logic                     o_valid,
  output logic [D*N-1:0]           o_taps,
  output logic [N-1:0]             o_vtaps,
  output logic [$clog2(N+1)-1:0]   o_cnt,
  output logic                     o_full
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [D-1:0]  data_q [N];
  logic [N-1:0]  valid_q;
  logic [CW-1:0] cnt_q;
  logic          full_q;
  logic [CW-1:0] cnt_nxt_c;

  // Stage 0 captures the inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q[0]  <= RST_VAL;
      valid_q[0] <= 1'b0;
    end else if (i_clr) begin
      data_q[0]  <= RST_VAL;
      valid_q[0] <= 1'b0;
    end else if (i_en) begin
      data_q[0]  <= i_data;
      valid_q[0] <= i_valid;
    end
  end

  // Stages 1..N-1 shift from their predecessor; data moves even when invalid.
  for (genvar k = 1; k < N; k++) begin : g_stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q[k]  <= RST_VAL;
        valid_q[k] <= 1'b0;
      end else if (i_clr) begin
        data_q[k]  <= RST_VAL;
        valid_q[k] <= 1'b0;
      end else if (i_en) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // Occupancy delta: +1 on entry, -1 on exit, unchanged when both or neither.
  always_comb begin
    cnt_nxt_c = cnt_q;
    if (i_valid && !valid_q[N-1]) begin
      cnt_nxt_c = cnt_q + CW'(1);
    end else if (!i_valid && valid_q[N-1]) begin
      cnt_nxt_c = cnt_q - CW'(1);
    end
  end

  // Counter and full flag, updated together so they stay coincident.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (i_clr) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (i_en) begin
      cnt_q  <= cnt_nxt_c;
      full_q <= (cnt_nxt_c == CW'(N));
    end
  end

  // Flatten stage registers onto the tap bus.
  for (genvar k = 0; k < N; k++) begin : g_taps
    assign o_taps[D*k +: D] = data_q[k];
  end

  assign o_data  = data_q[N-1];
  assign o_valid = valid_q[N-1];
  assign o_vtaps = valid_q;
  assign o_cnt   = cnt_q;
  assign o_full  = full_q;

  // The counter must always agree with the valid chain.
  a_cnt_popcount : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    cnt_q == CW'($countones(valid_q)));
  a_full_match : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    full_q == (cnt_q == CW'(N)));

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: four dff_pipe builds (N=4/RST 0, N=4/RST 00A5, N=1, N=8)
// share one stimulus stream. A history-based model predicts every output;
// directed literals pin the model at key points.
module tb_dff_pipe;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        en    = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data  = '0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  logic [15:0]  d0, d1, d2, d3;
  logic         v0, v1, v2, v3;
  logic [63:0]  t0, t1;
  logic [15:0]  t2;
  logic [127:0] t3;
  logic [3:0]   vt0, vt1;
  logic [0:0]   vt2;
  logic [7:0]   vt3;
  logic [2:0]   c0, c1;
  logic [0:0]   c2;
  logic [3:0]   c3;
  logic         f0, f1, f2, f3;

  dff_pipe #(.D(16), .N(4), .RST_VAL(16'h0000)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_en(en), .i_valid(valid),
    .i_data(data), .o_data(d0), .o_valid(v0), .o_taps(t0), .o_vtaps(vt0),
    .o_cnt(c0), .o_full(f0));
  dff_pipe #(.D(16), .N(4), .RST_VAL(16'h00A5)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_en(en), .i_valid(valid),
    .i_data(data), .o_data(d1), .o_valid(v1), .o_taps(t1), .o_vtaps(vt1),
    .o_cnt(c1), .o_full(f1));
  dff_pipe #(.D(16), .N(1), .RST_VAL(16'h0000)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_en(en), .i_valid(valid),
    .i_data(data), .o_data(d2), .o_valid(v2), .o_taps(t2), .o_vtaps(vt2),
    .o_cnt(c2), .o_full(f2));
  dff_pipe #(.D(16), .N(8), .RST_VAL(16'h0000)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_en(en), .i_valid(valid),
    .i_data(data), .o_data(d3), .o_valid(v3), .o_taps(t3), .o_vtaps(vt3),
    .o_cnt(c3), .o_full(f3));

  // Model: list of accepted samples since the last reset/clear, newest last.
  // Stage k holds the k-th most recent sample, or the reset value if none.
  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } ent_t;
  ent_t hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
    end else if (clr) begin
      hist.delete();
    end else if (en) begin
      hist.push_back('{v: valid, d: data});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_inst(input string nm, input int n, input logic [15:0] rv,
                            input logic [15:0] ad, input logic av,
                            input logic [127:0] at, input logic [7:0] avt,
                            input logic [3:0] ac, input logic af);
    logic [127:0] et;
    logic [7:0]   evt;
    logic [15:0]  ed;
    logic         ev;
    int           cnt;
    int           idx;
    et = '0; evt = '0; ed = rv; ev = 1'b0; cnt = 0;
    for (int k = 0; k < n; k++) begin
      idx = hist.size() - 1 - k;
      if (idx >= 0) begin
        et[16*k +: 16] = hist[idx].d;
        evt[k]         = hist[idx].v;
        if (hist[idx].v) cnt++;
        if (k == n - 1) begin ed = hist[idx].d; ev = hist[idx].v; end
      end else begin
        et[16*k +: 16] = rv;
        if (k == n - 1) begin ed = rv; ev = 1'b0; end
      end
    end
    cmp({nm, ".data"},  128'(ad),  128'(ed));
    cmp({nm, ".valid"}, 128'(av),  128'(ev));
    cmp({nm, ".taps"},  at,        et);
    cmp({nm, ".vtaps"}, 128'(avt), 128'(evt));
    cmp({nm, ".cnt"},   128'(ac),  128'(cnt));
    cmp({nm, ".full"},  128'(af),  128'(cnt == n));
  endtask

  task automatic check_all();
    check_inst("u0", 4, 16'h0000, d0, v0, 128'(t0), 8'(vt0), 4'(c0), f0);
    check_inst("u1", 4, 16'h00A5, d1, v1, 128'(t1), 8'(vt1), 4'(c1), f1);
    check_inst("u2", 1, 16'h0000, d2, v2, 128'(t2), 8'(vt2), 4'(c2), f2);
    check_inst("u3", 8, 16'h0000, d3, v3, t3,       vt3,     c3,     f3);
  endtask

  // Continuous compare, away from the active edge.
  always @(negedge clk) check_all();

  // Drive one cycle's inputs, then return 1 ns after the sampling edge.
  task automatic cyc(input logic e, input logic c, input logic v, input logic [15:0] d);
    en = e; clr = c; valid = v; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] feed [8];
    int          cexp [5];
    logic        bub  [8];
    logic        vexp [5];
    feed = '{16'h000F, 16'h003A, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    cexp = '{1, 2, 3, 4, 4};
    bub  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vexp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with enable and all-ones data.
    en = 1'b1; valid = 1'b1; data = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      cmp("rst.taps0", 128'(t0), 128'h0);
      cmp("rst.cnt0",  128'(c0), 128'h0);
      cmp("rst.taps1", 128'(t1), 128'(64'h00A5_00A5_00A5_00A5));
    end
    rst_n = 1'b1;

    // Latency and fill.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, feed[i]);
      cmp("fill.cnt0", 128'(c0), 128'(cexp[i]));
      if (i == 0) cmp("fill.n1_data", 128'(d2), 128'h000F);
      if (i == 3) begin
        cmp("fill.data0", 128'(d0), 128'h000F);
        cmp("fill.full0", 128'(f0), 128'h1);
      end
    end

    // Stall while toggling data.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 16'(16'hBEEF + i));
      cmp("stall.taps0", 128'(t0), 128'(64'h003A_0001_0002_0003));
      cmp("stall.cnt0",  128'(c0), 128'h4);
    end
    cyc(1'b1, 1'b0, 1'b1, 16'h0004);
    cmp("resume.data0", 128'(d0), 128'h0001);

    // Clear wins over enable; 1234 must not land.
    cyc(1'b1, 1'b1, 1'b1, 16'h1234);
    cmp("clr.taps0", 128'(t0), 128'h0);
    cmp("clr.cnt0",  128'(c0), 128'h0);
    cmp("clr.full0", 128'(f0), 128'h0);
    cmp("clr.taps1", 128'(t1), 128'(64'h00A5_00A5_00A5_00A5));

    // Bubbles.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, bub[i], 16'(16'h0100 + i));
      if (i >= 3) cmp("bub.valid0", 128'(v0), 128'(vexp[i-3]));
      if (i == 3) cmp("bub.cnt0_e4", 128'(c0), 128'h3);
    end
    cmp("bub.cnt0_drain", 128'(c0), 128'h0);

    // Half fill, then async reset pulse mid-cycle.
    cyc(1'b1, 1'b0, 1'b1, 16'h0A0A);
    cyc(1'b1, 1'b0, 1'b1, 16'h0B0B);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst.taps0",  128'(t0),  128'h0);
    cmp("arst.vtaps0", 128'(vt0), 128'h0);
    cmp("arst.cnt0",   128'(c0),  128'h0);
    cmp("arst.taps1",  128'(t1),  128'(64'h00A5_00A5_00A5_00A5));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b0, 16'h0000);

    // Refill: N=1 latency 1, N=8 latency 8.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, feed[i]);
      if (i == 0) cmp("refill.n1_data", 128'(d2), 128'h000F);
      if (i == 6) cmp("refill.n8_valid", 128'(v3), 128'h0);
      if (i == 7) begin
        cmp("refill.n8_data", 128'(d3), 128'h000F);
        cmp("refill.n8_full", 128'(f3), 128'h1);
      end
    end

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 1)), 16'($urandom));
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
